// File: rtl/gmii_rx.sv
// gmii_rx: GMII receiver for the UDP/IPv4 video+audio link, demuxing payload to video and aux write ports
module gmii_rx #(
  parameter logic [47:0] my_mac = 48'h002345678902,
  parameter logic [15:0] ip_type = 16'h0800,
  parameter logic [7:0] ip_prot = 8'h11,
  parameter logic [15:0] udp_dport = 16'h3039,
  parameter logic [10:0] vid_bytes = 11'd1200,
  parameter logic [5:0] aux_bytes = 6'd32
) (
  input logic rx_clk,
  input logic sys_rst,
  input logic id,
  input logic rx_dv,
  input logic rx_er,
  input logic [7:0] rxd,
  output logic vid_wr_en,
  output logic [15:0] vid_data,
  output logic [15:0] vid_line,
  output logic vid_sol,
  output logic aux_hdr_valid,
  output logic [15:0] aux_hdr,
  output logic aux_wr_en,
  output logic [7:0] aux_data,
  output logic frame_ok,
  output logic frame_err,
  output logic [15:0] crc_err_cnt
);
  localparam logic [31:0] crc_poly = 32'hedb88320;
  localparam logic [31:0] crc_res = 32'hdebb20e3;
  typedef enum logic [3:0] {IDLE, PRE, HDR, PKTID, RESOL, VIDEO, AUXID, AUX, TAIL, DROP} state_t;
  state_t state, state_n;
  logic armed, first, post, in_frame, guard, abort, live, crc_good;
  logic ok_d, err_d, vwr_d, ahv_d, awr_d, hdr_chk;
  logic [10:0] idx, total;
  logic [7:0] ptype, hold, hdr_exp;
  logic [4:0] remaining;
  logic [31:0] crc, crc_n;
  logic [47:0] dst;
  // Expected header byte for the filtered positions; others are don't-care
  always_comb begin
    dst = my_mac - {47'd0, id};
    hdr_chk = 1'b1;
    hdr_exp = 8'h00;
    case (idx)
      11'd0: hdr_exp = dst[47:40];
      11'd1: hdr_exp = dst[39:32];
      11'd2: hdr_exp = dst[31:24];
      11'd3: hdr_exp = dst[23:16];
      11'd4: hdr_exp = dst[15:8];
      11'd5: hdr_exp = dst[7:0];
      11'd12: hdr_exp = ip_type[15:8];
      11'd13: hdr_exp = ip_type[7:0];
      11'd23: hdr_exp = ip_prot;
      11'd36: hdr_exp = udp_dport[15:8];
      11'd37: hdr_exp = udp_dport[7:0];
      default: hdr_chk = 1'b0;
    endcase
  end
  // Reflected CRC-32 byte update; crc_res is the reflected form of residue C704DD7B
  always_comb begin
    crc_n = crc ^ {24'd0, rxd};
    for (int i = 0; i < 8; i++) crc_n = crc_n[0] ? (crc_n >> 1) ^ crc_poly : crc_n >> 1;
  end
  // Frame-level error and verdict conditions
  always_comb begin
    post = state inside {RESOL, VIDEO, AUXID, AUX, TAIL};
    in_frame = post || state inside {HDR, PKTID};
    guard = rx_dv && in_frame && total == 11'd1600;
    abort = guard || (post && (rx_dv ? rx_er : state != TAIL));
    live = rx_dv && !abort;
    crc_good = idx == 11'd4 && crc == crc_res;
    ok_d = state == TAIL && !rx_dv && crc_good;
    err_d = abort || (state == TAIL && !rx_dv && !crc_good);
  end
  // State register
  always_ff @(posedge rx_clk)
    state <= sys_rst ? IDLE : state_n;
  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (rx_dv && armed) state_n = rxd == 8'h55 ? PRE : DROP;
      PRE: state_n = !rx_dv ? IDLE : rx_er ? DROP : rxd == 8'h55 ? PRE : rxd == 8'hd5 ? HDR : DROP;
      HDR: state_n = !rx_dv ? IDLE : (rx_er || (hdr_chk && rxd != hdr_exp)) ? DROP : idx == 11'd41 ? PKTID : HDR;
      PKTID: state_n = !rx_dv ? IDLE : rx_er ? DROP : (rxd == 8'h00 || rxd == 8'h02) ? RESOL : rxd == 8'h01 ? AUXID : DROP;
      RESOL: if (idx == 11'd1) state_n = VIDEO;
      VIDEO: if (idx == vid_bytes - 11'd1) state_n = ptype == 8'h02 ? AUXID : TAIL;
      AUXID: if (idx == 11'd1) state_n = AUX;
      AUX: if (idx == {5'd0, aux_bytes} - 11'd1) state_n = remaining == 5'd0 ? TAIL : AUXID;
      TAIL: state_n = TAIL;
      DROP: if (!rx_dv) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (post) state_n = !rx_dv ? IDLE : rx_er ? DROP : state_n;
    if (guard) state_n = DROP;
  end
  // Output strobe decode
  always_comb begin
    vwr_d = live && state == VIDEO && idx[0];
    ahv_d = live && state == AUXID && idx == 11'd1;
    awr_d = live && state == AUX;
  end
  // Datapath, counters and registered outputs
  always_ff @(posedge rx_clk) begin
    if (sys_rst) begin
      armed <= 1'b0;
      first <= 1'b0;
      idx <= '0;
      total <= '0;
      crc <= '1;
      ptype <= '0;
      hold <= '0;
      remaining <= '0;
      vid_wr_en <= 1'b0;
      vid_data <= '0;
      vid_line <= '0;
      vid_sol <= 1'b0;
      aux_hdr_valid <= 1'b0;
      aux_hdr <= '0;
      aux_wr_en <= 1'b0;
      aux_data <= '0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      crc_err_cnt <= '0;
    end else begin
      armed <= armed | ~rx_dv;
      idx <= state_n != state ? 11'd0 : idx + 11'd1;
      total <= state == PRE ? 11'd0 : (rx_dv && total < 11'd1600) ? total + 11'd1 : total;
      crc <= state == PRE ? 32'hffffffff : (rx_dv && in_frame) ? crc_n : crc;
      hold <= rxd;
      if (state == PKTID) ptype <= rxd;
      if (live && state == RESOL && idx == 11'd1) vid_line <= {hold, rxd};
      first <= state == RESOL ? 1'b1 : vwr_d ? 1'b0 : first;
      vid_wr_en <= vwr_d;
      vid_sol <= vwr_d && first;
      if (vwr_d) vid_data <= {hold, rxd};
      aux_hdr_valid <= ahv_d;
      if (ahv_d) aux_hdr <= {hold, rxd};
      if (ahv_d) remaining <= rxd[7:3];
      aux_wr_en <= awr_d;
      if (awr_d) aux_data <= rxd;
      frame_ok <= ok_d;
      frame_err <= err_d;
      if (err_d && crc_err_cnt != 16'hffff) crc_err_cnt <= crc_err_cnt + 16'd1;
    end
  end
endmodule
